// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial push-button adder.
//   state_t    : controller states; the encoding is the externally visible
//                phase code (LD_AL=0 .. DONE=5)
//   NIBBLE_W   : width of the switch bus / one operand load
//   bit_cnt_w  : width of the RUN bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [2:0] {
    LD_AL = 3'd0,
    LD_AH = 3'd1,
    LD_BL = 3'd2,
    LD_BH = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Counter must index bits 0..width-1.
  function automatic int bit_cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell, time-shared by the serial adder.
//   i_a, i_b : operand bits
//   i_c      : carry in
//   o_s      : sum bit
//   o_c      : carry out (majority of the three inputs)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/pb_edge.sv
// -----------------------------------------------------------------------------
// pb_edge
// Push-button conditioner: 2-flop synchronizer, optional debounce filter,
// then a registered rising-edge detector that emits a single-cycle pulse.
// A held button gives exactly one pulse.
//
// Build option: define SA_DEBOUNCE_EN to insert the debounce filter. The
// filtered level only follows the synchronized input after it has been stable
// for DEB_CYCLES consecutive cycles, which adds DEB_CYCLES cycles of latency.
// Without it the pulse appears 3 clk after the raw edge.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   i_btn    : raw (asynchronous) button level
//   o_pulse  : one-cycle pulse on a press
// -----------------------------------------------------------------------------
module pb_edge #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("pb_edge: DEB_CYCLES must be at least 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic r_pulse;
  logic w_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SA_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_filt;

  // Count consecutive cycles in which the synced input disagrees with the
  // filtered level; any agreement restarts the count, so glitches shorter
  // than DEB_CYCLES never reach the filtered level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_cnt <= '0;
      r_filt    <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_deb_cnt <= '0;
      r_filt    <= r_sync2;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_pulse   <= w_level & ~r_level_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial unsigned adder driven by two push buttons and a 4-bit switch bus.
// Operands A and B are loaded one nibble at a time (low then high), then a
// single full_adder cell is stepped through WIDTH cycles. sum/carry update
// atomically on DONE entry and otherwise hold their previous values.
//
// Build option: SA_DEBOUNCE_EN (forwarded to pb_edge) adds a DEB_CYCLES
// debounce filter on both buttons.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   pb_next  : raw button, capture Y into the current nibble and advance
//   pb_clear : raw button, abort and clear operands/result
//   Y        : switch nibble
//   sum      : WIDTH-bit result
//   carry    : carry out of the MSB (2^WIDTH bit)
//   done     : high in DONE
//   busy     : high in RUN
//   phase    : state code (LD_AL=0 .. DONE=5)
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int DEB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pb_next,
  input  logic                pb_clear,
  input  logic [NIBBLE_W-1:0] Y,
  output logic [WIDTH-1:0]    sum,
  output logic                carry,
  output logic                done,
  output logic                busy,
  output logic [2:0]          phase
);

  if (WIDTH < 5 || WIDTH > 8) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be in 5..8");
  end

  localparam int                 CNT_W    = bit_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;

  logic w_next_pulse;
  logic w_clr_pulse;
  logic w_ld_al;
  logic w_ld_ah;
  logic w_ld_bl;
  logic w_ld_bh;
  logic w_step;
  logic w_last;
  logic w_fa_s;
  logic w_fa_c;

  pb_edge #(.DEB_CYCLES(DEB_CYCLES)) u_pb_next (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (pb_next),
    .o_pulse (w_next_pulse)
  );

  pb_edge #(.DEB_CYCLES(DEB_CYCLES)) u_pb_clear (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (pb_clear),
    .o_pulse (w_clr_pulse)
  );

  full_adder u_fa (
    .i_a (r_a[r_cnt]),
    .i_b (r_b[r_cnt]),
    .i_c (r_c),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LD_AL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath strobes. Clear takes priority over everything,
  // including a next pulse in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_ld_al      = 1'b0;
    w_ld_ah      = 1'b0;
    w_ld_bl      = 1'b0;
    w_ld_bh      = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    if (w_clr_pulse) begin
      w_state_next = LD_AL;
    end else begin
      case (r_state)
        LD_AL: if (w_next_pulse) begin w_ld_al = 1'b1; w_state_next = LD_AH; end
        LD_AH: if (w_next_pulse) begin w_ld_ah = 1'b1; w_state_next = LD_BL; end
        LD_BL: if (w_next_pulse) begin w_ld_bl = 1'b1; w_state_next = LD_BH; end
        LD_BH: if (w_next_pulse) begin w_ld_bh = 1'b1; w_state_next = RUN;   end
        RUN: begin
          w_step = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_last       = 1'b1;
            w_state_next = DONE;
          end
        end
        DONE:  if (w_next_pulse) begin w_ld_al = 1'b1; w_state_next = LD_AH; end
        default: w_state_next = LD_AL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clr_pulse) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
    end else begin
      if (w_ld_al) r_a[NIBBLE_W-1:0]     <= Y;
      if (w_ld_ah) r_a[WIDTH-1:NIBBLE_W] <= Y[WIDTH-NIBBLE_W-1:0];
      if (w_ld_bl) r_b[NIBBLE_W-1:0]     <= Y;
      if (w_ld_bh) begin
        r_b[WIDTH-1:NIBBLE_W] <= Y[WIDTH-NIBBLE_W-1:0];
        r_cnt                 <= '0;
        r_c                   <= 1'b0;
      end
      if (w_step) begin
        // Sum bits enter at the top and shift down, so after WIDTH-1 steps
        // bit 0 sits at the LSB and the final bit completes the word.
        r_acc <= {w_fa_s, r_acc[WIDTH-2:1]};
        r_c   <= w_fa_c;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_last) begin
        r_sum   <= {w_fa_s, r_acc};
        r_carry <= w_fa_c;
      end
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;
  assign done  = (r_state == DONE);
  assign busy  = (r_state == RUN);
  assign phase = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl (WIDTH=7). Buttons are driven on the
// falling edge and outputs sampled there, away from the active edge. With
// SA_DEBOUNCE_EN defined the button latency grows and a glitch test is added.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int WIDTH = 7;
`ifdef SA_DEBOUNCE_EN
  localparam int LAT = 19;   // raw press to pulse, with 16-cycle filter
`else
  localparam int LAT = 3;    // raw press to pulse
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             pb_next;
  logic             pb_clear;
  logic [3:0]       Y;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             done;
  logic             busy;
  logic [2:0]       phase;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .pb_next  (pb_next),
    .pb_clear (pb_clear),
    .Y        (Y),
    .sum      (sum),
    .carry    (carry),
    .done     (done),
    .busy     (busy),
    .phase    (phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expd);
    n_checks++;
    if (got !== expd) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, expd);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_next(input logic [3:0] y);
    Y       = y;
    pb_next = 1'b1;
    tick(LAT + 1);
    pb_next = 1'b0;
    tick(LAT + 4);
  endtask

  task automatic press_clear();
    pb_clear = 1'b1;
    tick(LAT + 1);
    pb_clear = 1'b0;
    tick(LAT + 4);
  endtask

  // Load four nibbles and check the finished result.
  task automatic run_nib(input logic [3:0] y0, input logic [3:0] y1,
                         input logic [3:0] y2, input logic [3:0] y3,
                         input logic [6:0] esum, input logic ecarry, input string tag);
    press_next(y0);
    press_next(y1);
    press_next(y2);
    press_next(y3);
    tick(4);
    $display("add %s: Y=%h,%h,%h,%h sum=0x%02h carry=%0d done=%0d (expect sum=0x%02h carry=%0d)",
             tag, y0, y1, y2, y3, sum, carry, done, esum, ecarry);
    check({tag, "_sum"},   32'(sum),   32'(esum));
    check({tag, "_carry"}, 32'(carry), 32'(ecarry));
    check({tag, "_done"},  32'(done),  1);
    check({tag, "_phase"}, 32'(phase), 5);
  endtask

  task automatic run_add(input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] esum, input logic ecarry, input string tag);
    run_nib(a[3:0], {1'b0, a[6:4]}, b[3:0], {1'b0, b[6:4]}, esum, ecarry, tag);
  endtask

  int busy_cnt;
  int done_at;
  int partial;

  initial begin
    rst = 1'b1; pb_next = 1'b0; pb_clear = 1'b0; Y = 4'h0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_phase", 32'(phase), 0);
    check("rst_sum",   32'(sum),   0);
    check("rst_carry", 32'(carry), 0);
    check("rst_done",  32'(done),  0);
    check("rst_busy",  32'(busy),  0);

    // 0x2A + 0x15 with capture latency and RUN/DONE timing.
    Y = 4'hA; pb_next = 1'b1;
    tick(LAT);
    check("lat_before", 32'(phase), 0);
    tick(1);
    check("lat_capture", 32'(phase), 1);
    pb_next = 1'b0;
    tick(LAT + 4);
    press_next(4'h2);
    press_next(4'h5);
    Y = 4'h1; pb_next = 1'b1;
    busy_cnt = 0; done_at = 0; partial = 0;
    for (int k = 1; k <= LAT + 12; k++) begin
      tick(1);
      if (k == LAT + 1) pb_next = 1'b0;
      if (busy) busy_cnt++;
      if (busy && (sum !== 7'h00 || carry !== 1'b0)) partial = 1;
      if (done && done_at == 0) done_at = k;
    end
    $display("add t1: A=0x2A B=0x15 sum=0x%02h carry=%0d done_at=%0d busy_cycles=%0d",
             sum, carry, done_at, busy_cnt);
    check("t1_done_cycle", done_at, LAT + 8);
    check("t1_busy_cycles", busy_cnt, 7);
    check("t1_no_partial", partial, 0);
    check("t1_sum",   32'(sum),   'h3F);
    check("t1_carry", 32'(carry), 0);
    check("t1_done",  32'(done),  1);
    tick(LAT + 4);

    // Wrap-around cases, each started from DONE.
    run_add(7'h7F, 7'h01, 7'h00, 1'b1, "wrap1");
    run_add(7'h7F, 7'h7F, 7'h7E, 1'b1, "wrap2");

    // High nibble 0xF: Y[3] dropped, A = 0x73.
    run_nib(4'h3, 4'hF, 4'h0, 4'h0, 7'h73, 1'b0, "ah_trunc");

    // Clear pulse lands in RUN cycle 3.
    press_next(4'hE);
    press_next(4'h1);
    press_next(4'h3);
    Y = 4'h2; pb_next = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      tick(1);
      if (k == 3) pb_clear = 1'b1;
      if (k == LAT + 1) pb_next = 1'b0;
      if (k == LAT + 3) check("clr_busy_before", 32'(busy), 1);
      if (k == LAT + 4) begin
        check("clr_phase", 32'(phase), 0);
        check("clr_busy",  32'(busy),  0);
        check("clr_sum",   32'(sum),   0);
        check("clr_done",  32'(done),  0);
      end
    end
    pb_clear = 1'b0;
    tick(LAT + 4);
    run_add(7'h1E, 7'h23, 7'h41, 1'b0, "after_clr");

    // Simultaneous next + clear in LD_BL.
    press_next(4'h4);
    press_next(4'h1);
    check("sim_pre_phase", 32'(phase), 2);
    Y = 4'h6; pb_next = 1'b1; pb_clear = 1'b1;
    tick(LAT + 1);
    check("sim_phase", 32'(phase), 0);
    pb_next = 1'b0; pb_clear = 1'b0;
    tick(LAT + 4);

    // Held button: one capture only.
    Y = 4'h5; pb_next = 1'b1;
    tick(100);
    check("held_one_capture", 32'(phase), 1);
    pb_next = 1'b0;
    tick(LAT + 4);
    press_clear();
    check("clr_from_ldah", 32'(phase), 0);

    // Next pulse during RUN is ignored.
    press_next(4'hA);
    press_next(4'h2);
    press_next(4'h5);
    Y = 4'h1; pb_next = 1'b1;
    for (int k = 1; k <= LAT + 12; k++) begin
      tick(1);
      if (k == LAT + 1) pb_next = 1'b0;
      if (k == LAT + 2) pb_next = 1'b1;
      if (k == LAT + 6) pb_next = 1'b0;
    end
    tick(2 * LAT + 8);
    $display("add ign: A=0x2A B=0x15 with press in RUN sum=0x%02h carry=%0d phase=%0d",
             sum, carry, phase);
    check("ign_phase", 32'(phase), 5);
    check("ign_sum",   32'(sum),   'h3F);
    check("ign_carry", 32'(carry), 0);

`ifdef SA_DEBOUNCE_EN
    // 10-cycle glitch is filtered; a 20-cycle press captures once.
    Y = 4'h7; pb_next = 1'b1;
    tick(10);
    pb_next = 1'b0;
    tick(30);
    check("deb_glitch", 32'(phase), 5);
    pb_next = 1'b1;
    tick(LAT);
    check("deb_before", 32'(phase), 5);
    tick(1);
    check("deb_capture", 32'(phase), 1);
    pb_next = 1'b0;
    tick(LAT + 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
